// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
// master: datapath side (drives ID/EX status, consumes controls); slave: controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             stats_clr;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             idex_flush;
  logic             pipe_freeze;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1,
    output id_rs2,
    output id_uses_rs1,
    output id_uses_rs2,
    output ex_mem_read,
    output ex_reg_write,
    output ex_rd,
    output ex_branch_taken,
    output mem_busy,
    output stats_clr,
    input  pc_write_en,
    input  ifid_write_en,
    input  ifid_flush,
    input  idex_bubble,
    input  idex_flush,
    input  pipe_freeze,
    input  stall_count,
    input  flush_count
  );

  modport slave (
    input  id_rs1,
    input  id_rs2,
    input  id_uses_rs1,
    input  id_uses_rs2,
    input  ex_mem_read,
    input  ex_reg_write,
    input  ex_rd,
    input  ex_branch_taken,
    input  mem_busy,
    input  stats_clr,
    output pc_write_en,
    output ifid_write_en,
    output ifid_flush,
    output idex_bubble,
    output idex_flush,
    output pipe_freeze,
    output stall_count,
    output flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LEGv8 pipeline.
// Ports: clk, reset_n (async active-low), bus (slave modport): ID/EX
// hazard inputs, branch, mem_busy, stats_clr in; PC/IF-ID/ID-EX
// write/bubble/flush/freeze controls and saturating counters out.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } state_e;

  localparam logic [3:0] REM_INIT =
    4'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q;
  state_e           state_d;
  logic [3:0]       rem_q;
  logic [3:0]       rem_d;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] flush_d;

  logic hazard;
  logic rs1_hit;
  logic rs2_hit;
  logic sel_busy;
  logic sel_branch;
  logic sel_hold;
  logic sel_hazard;
  logic sel_normal;

  logic pc_we;
  logic ifid_we;
  logic ifid_fl;
  logic idex_bub;
  logic idex_fl;
  logic freeze;

  // X31 is XZR: a load "into" it never produces a value to wait for.
  always_comb begin
    rs1_hit = bus.id_uses_rs1 &&
              (bus.id_rs1 == bus.ex_rd);
    rs2_hit = bus.id_uses_rs2 &&
              (bus.id_rs2 == bus.ex_rd);
    hazard  = bus.ex_mem_read &&
              bus.ex_reg_write &&
              (bus.ex_rd != 5'd31) &&
              (rs1_hit || rs2_hit);
  end

  // Flatten the priority chain into one-hot selects.
  always_comb begin
    sel_busy   = bus.mem_busy;
    sel_branch = !bus.mem_busy &&
                 bus.ex_branch_taken;
    sel_hold   = !bus.mem_busy &&
                 !bus.ex_branch_taken &&
                 (state_q == LOAD_STALL);
    sel_hazard = !bus.mem_busy &&
                 !bus.ex_branch_taken &&
                 (state_q == RUN) &&
                 hazard;
    sel_normal = !bus.mem_busy &&
                 !bus.ex_branch_taken &&
                 (state_q == RUN) &&
                 !hazard;
  end

  always_comb begin
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    ifid_fl  = 1'b0;
    idex_bub = 1'b0;
    idex_fl  = 1'b0;
    freeze   = 1'b0;
    state_d  = state_q;
    rem_d    = rem_q;

    unique case (1'b1)
      sel_busy: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        freeze  = 1'b1;
      end
      sel_branch: begin
        ifid_fl = 1'b1;
        idex_fl = 1'b1;
        state_d = RUN;
        rem_d   = 4'd0;
      end
      sel_hold: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_bub = 1'b1;
        rem_d    = rem_q - 4'd1;
        if (rem_q == 4'd1) begin
          state_d = RUN;
        end
      end
      sel_hazard: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_bub = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          state_d = LOAD_STALL;
          rem_d   = REM_INIT;
        end
      end
      sel_normal: begin
        pc_we = 1'b1;
      end
    endcase

    // Held in reset: keep the pipe inert and flushed.
    if (!reset_n) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      ifid_fl  = 1'b1;
      idex_bub = 1'b1;
      idex_fl  = 1'b1;
      freeze   = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_we && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
    if (sel_branch && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_ONE;
    end
    if (bus.stats_clr) begin
      stall_d = '0;
      flush_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      rem_q   <= 4'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_write_en   = pc_we;
  assign bus.ifid_write_en = ifid_we;
  assign bus.ifid_flush    = ifid_fl;
  assign bus.idex_bubble   = idex_bub;
  assign bus.idex_flush    = idex_fl;
  assign bus.pipe_freeze   = freeze;
  assign bus.stall_count   = stall_q;
  assign bus.flush_count   = flush_q;

endmodule
